// File: rtl/iob_rtc_gen_pkg.sv
// Shared definitions for the real-time clock generator:
// register map and control/status bit positions.
package iob_rtc_gen_pkg;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_INC    = 2'd1,
      REG_TICKS  = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_INC    = 4'h4;
   localparam logic [3:0] OFF_TICKS  = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_CLR    = 1;
   localparam int STATUS_PEND = 0;
   localparam int TICKS_W     = 32;

endpackage

// File: rtl/iob_rtc_nco.sv
// Phase accumulator producing rt_clk/rt_tick, with a shadowed increment
// that only swaps in on a falling edge, a clear, or while disabled.
module iob_rtc_nco
   import iob_rtc_gen_pkg::*;
#(
   parameter int ACC_W   = 32,
   parameter int INC_RST = 1407375
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             inc_wr,
   input  logic [ACC_W-1:0] inc_val,
   output logic             rt_clk,
   output logic             rt_tick,
   output logic             tick_nxt,
   output logic [ACC_W-1:0] inc_pend,
   output logic             pending
);

   localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] INC_RST_V = ACC_W'(INC_RST);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_act;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic             upd;
   logic [ACC_W-1:0] inc_sat;

   always_comb begin
      sum      = {1'b0, acc} + {1'b0, inc_act};
      carry    = en & sum[ACC_W];
      // carry coincides with the rt_clk falling edge, so the high phase stays whole
      upd      = clr | ~en | carry;
      tick_nxt = en & ~clr & ~rt_clk & sum[ACC_W-1];
      inc_sat  = (inc_val > INC_MAX) ? INC_MAX : inc_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         rt_clk   <= 1'b0;
         rt_tick  <= 1'b0;
         inc_act  <= INC_RST_V;
         inc_pend <= INC_RST_V;
         pending  <= 1'b0;
      end else begin
         rt_tick <= tick_nxt;
         if (clr) begin
            acc    <= '0;
            rt_clk <= 1'b0;
         end else if (en) begin
            acc    <= sum[ACC_W-1:0];
            rt_clk <= sum[ACC_W-1];
         end
         if (upd) inc_act <= inc_pend;
         if (inc_wr) begin
            inc_pend <= inc_sat;
            pending  <= 1'b1;
         end else if (upd) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/iob_rtc_gen.sv
// CLINT real-time clock generator: IOb native bus CSRs, tick counter
// and the NCO that produces rt_clk from the system clock.
module iob_rtc_gen
   import iob_rtc_gen_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int ACC_W   = 32,
   parameter int INC_RST = 1407375,
   parameter int EN_RST  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   output logic                rt_clk,
   output logic                rt_tick
);

   reg_sel_e           sel;
   logic               wr;
   logic               ctrl_wr;
   logic               clr;
   logic               inc_wr;
   logic               en_q;
   logic [TICKS_W-1:0] ticks;
   logic               tick_nxt;
   logic [ACC_W-1:0]   inc_pend;
   logic               pending;
   logic [DATA_W-1:0]  pend_ext;
   logic [DATA_W-1:0]  inc_mrg;
   logic [ACC_W-1:0]   inc_val;
   logic [DATA_W-1:0]  rd_mux;
   logic               addr_unused;

   assign addr_unused = ^address[1:0];

   always_comb begin
      sel     = reg_sel_e'(address[3:2]);
      wr      = valid & (|wstrb);
      ctrl_wr = wr & (sel == REG_CTRL) & wstrb[0];
      clr     = ctrl_wr & wdata[CTRL_CLR];
      inc_wr  = wr & (sel == REG_INC);
   end

   // byte-merge the write into the pending value before saturation
   always_comb begin
      pend_ext = '0;
      pend_ext[ACC_W-1:0] = inc_pend;
      inc_mrg = pend_ext;
      for (int i = 0; i < DATA_W/8; i++) begin
         if (wstrb[i]) inc_mrg[8*i +: 8] = wdata[8*i +: 8];
      end
      inc_val = inc_mrg[ACC_W-1:0];
   end

   always_comb begin
      rd_mux = '0;
      unique case (sel)
         REG_CTRL:   rd_mux[CTRL_EN] = en_q;
         REG_INC:    rd_mux[ACC_W-1:0] = inc_pend;
         REG_TICKS:  rd_mux[TICKS_W-1:0] = ticks;
         REG_STATUS: rd_mux[STATUS_PEND] = pending;
         default:    rd_mux = '0;
      endcase
   end

   iob_rtc_nco #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_RST)
   ) u_nco (
      .clk      (clk),
      .rst      (rst),
      .en       (en_q),
      .clr      (clr),
      .inc_wr   (inc_wr),
      .inc_val  (inc_val),
      .rt_clk   (rt_clk),
      .rt_tick  (rt_tick),
      .tick_nxt (tick_nxt),
      .inc_pend (inc_pend),
      .pending  (pending)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q  <= (EN_RST != 0);
         ticks <= '0;
         ready <= 1'b0;
         rdata <= '0;
      end else begin
         ready <= valid;
         rdata <= valid ? rd_mux : '0;
         if (ctrl_wr) en_q <= wdata[CTRL_EN];
         if (clr) ticks <= '0;
         else if (tick_nxt) ticks <= ticks + 1'b1;
      end
   end

endmodule

// File: tb/tb_iob_rtc_gen.sv
// Scoreboarded bench for iob_rtc_gen: bus reads push expectations,
// a negedge monitor pops them when ready returns.
module tb_iob_rtc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [3:0]  address;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;
   logic        rt_clk;
   logic        rt_tick;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          chk;
      logic [31:0] exp;
      string       nm;
   } sb_t;

   sb_t sb_q[$];
   sb_t mon_e;

   always #5 clk = ~clk;

   iob_rtc_gen dut (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid),
      .address (address),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .rdata   (rdata),
      .ready   (ready),
      .rt_clk  (rt_clk),
      .rt_tick (rt_tick)
   );

   always @(negedge clk) begin
      if (ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_ready rdata=%0h", rdata);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
               total++;
               if (rdata !== mon_e.exp) begin
                  bad++;
                  $display("FAIL %s got=%0h exp=%0h", mon_e.nm, rdata, mon_e.exp);
               end
            end
         end
      end
   end

   // one bus cycle starting at a negedge; returns at the next negedge
   task automatic bus(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit chk,
                      input logic [31:0] exp, input string nm);
      sb_t e;
      valid   = 1'b1;
      address = a;
      wdata   = d;
      wstrb   = s;
      e.chk = chk;
      e.exp = exp;
      e.nm  = nm;
      sb_q.push_back(e);
      @(negedge clk);
      valid = 1'b0;
      wstrb = '0;
   endtask

   task automatic test_reset();
      total++;
      if (rt_clk !== 1'b0) begin
         bad++;
         $display("FAIL rst_rt_clk got=%0b exp=0", rt_clk);
      end
      total++;
      if (ready !== 1'b0 || rdata !== 32'h0) begin
         bad++;
         $display("FAIL rst_bus got=%0b/%0h exp=0/0", ready, rdata);
      end
      bus(4'h4, 0, 4'h0, 1, 32'd1407375, "rst_inc");
      bus(4'h8, 0, 4'h0, 1, 32'd0, "rst_ticks");
      bus(4'h0, 0, 4'h0, 1, 32'h1, "rst_ctrl");
      bus(4'hC, 0, 4'h0, 1, 32'h0, "rst_status");
   endtask

   task automatic test_period4();
      logic er;
      logic et;
      bus(4'h4, 32'h4000_0000, 4'hF, 0, 0, "w_inc");
      bus(4'h0, 32'h3, 4'hF, 0, 0, "w_ctrl");
      total++;
      if (rt_clk !== 1'b0) begin
         bad++;
         $display("FAIL p4_clr got=%0b exp=0", rt_clk);
      end
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         er = ((k-2) % 4 == 1) || ((k-2) % 4 == 2);
         et = ((k-2) % 4 == 1);
         total++;
         if (rt_clk !== er || rt_tick !== et) begin
            bad++;
            $display("FAIL p4_wave k=%0d got=%0b%0b exp=%0b%0b", k, rt_clk, rt_tick, er, et);
         end
      end
      bus(4'h8, 0, 4'h0, 1, 32'd10, "p4_ticks");
   endtask

   task automatic test_inc_change();
      logic er;
      logic et;
      bus(4'h4, 32'h2000_0000, 4'hF, 0, 0, "w_inc");
      bus(4'hC, 0, 4'h0, 1, 32'h1, "chg_pend0");
      bus(4'hC, 0, 4'h0, 1, 32'h1, "chg_pend1");
      bus(4'hC, 0, 4'h0, 1, 32'h1, "chg_pend2");
      bus(4'hC, 0, 4'h0, 1, 32'h0, "chg_pend_clr");
      for (int k = 47; k <= 62; k++) begin
         @(negedge clk);
         er = ((k-45) % 8) >= 4;
         et = ((k-45) % 8) == 4;
         total++;
         if (rt_clk !== er || rt_tick !== et) begin
            bad++;
            $display("FAIL p8_wave k=%0d got=%0b%0b exp=%0b%0b", k, rt_clk, rt_tick, er, et);
         end
      end
   endtask

   task automatic test_saturate();
      bus(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, "w_inc");
      bus(4'h4, 0, 4'h0, 1, 32'h8000_0000, "sat_inc");
      bus(4'h0, 32'h3, 4'hF, 0, 0, "w_ctrl");
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         total++;
         if (rt_clk !== 1'(j % 2) || rt_tick !== 1'(j % 2)) begin
            bad++;
            $display("FAIL p2_wave j=%0d got=%0b%0b exp=%0b", j, rt_clk, rt_tick, 1'(j % 2));
         end
      end
      bus(4'h8, 0, 4'h0, 1, 32'd4, "p2_ticks");
   endtask

   task automatic test_freeze();
      bus(4'h0, 32'h0, 4'hF, 0, 0, "w_ctrl");
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         total++;
         if (rt_clk !== 1'b0 || rt_tick !== 1'b0) begin
            bad++;
            $display("FAIL frz j=%0d got=%0b%0b exp=00", j, rt_clk, rt_tick);
         end
      end
      bus(4'h8, 0, 4'h0, 1, 32'd5, "frz_ticks");
      bus(4'h0, 0, 4'h0, 1, 32'h0, "frz_ctrl");
      bus(4'h0, 32'h3, 4'hF, 0, 0, "w_ctrl");
      bus(4'h8, 0, 4'h0, 1, 32'd0, "restart_ticks0");
      total++;
      if (rt_clk !== 1'b1 || rt_tick !== 1'b1) begin
         bad++;
         $display("FAIL restart_rise got=%0b%0b exp=11", rt_clk, rt_tick);
      end
      bus(4'h8, 0, 4'h0, 1, 32'd1, "restart_ticks1");
   endtask

   task automatic test_back_to_back();
      bus(4'h4, 32'h1234_5678, 4'hF, 0, 0, "w_inc");
      bus(4'h4, 32'h0000_CD00, 4'h2, 0, 0, "w_inc_b1");
      bus(4'h4, 0, 4'h0, 1, 32'h1234_CD78, "b2b_inc");
      bus(4'h2, 0, 4'h0, 1, 32'h1, "b2b_ctrl_lo");
      bus(4'h5, 0, 4'h0, 1, 32'h1234_CD78, "b2b_inc_lo");
      bus(4'h3, 0, 4'h0, 1, 32'h1, "b2b_ctrl_hi");
   endtask

   task automatic test_async_reset();
      bus(4'h4, 32'h4000_0000, 4'hF, 0, 0, "w_inc");
      bus(4'h0, 32'h3, 4'hF, 0, 0, "w_ctrl");
      @(negedge clk);
      bus(4'h0, 0, 4'h0, 1, 32'h1, "ar_ctrl");
      total++;
      if (rt_clk !== 1'b1 || rt_tick !== 1'b1) begin
         bad++;
         $display("FAIL ar_pre got=%0b%0b exp=11", rt_clk, rt_tick);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (rt_clk !== 1'b0 || rt_tick !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) begin
         bad++;
         $display("FAIL ar_out got=%0b%0b%0b/%0h exp=000/0", rt_clk, rt_tick, ready, rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      bus(4'h4, 0, 4'h0, 1, 32'd1407375, "ar_inc");
      bus(4'h0, 0, 4'h0, 1, 32'h1, "ar_ctrl2");
      bus(4'h8, 0, 4'h0, 1, 32'd0, "ar_ticks");
   endtask

   initial begin
      rst     = 1'b1;
      valid   = 1'b0;
      address = '0;
      wdata   = '0;
      wstrb   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_period4();
      test_inc_change();
      test_saturate();
      test_freeze();
      test_back_to_back();
      test_async_reset();
      repeat (3) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain left=%0d exp=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
